// File: rtl/muldiv_unit.sv
// Sequential RV32M multiply/divide unit (shift-add multiply, restoring divide, one bit per clock).
// Latency: N+1 edges from the start edge to done/result; divide-by-zero and signed overflow take 1 edge.
// Backpressure: none; start is only sampled while idle, and busy stalls the issuing pipeline.
//
// Ports:
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   start        request, accepted only in IDLE
//   funct3       000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   a, b         rs1 / rs2 operands; latched on the accepted start edge
//   busy         high from the start edge until the result edge
//   done         one-cycle pulse alongside a freshly loaded result
//   result       registered result, held until overwritten by the next operation
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched operation and sign information
  logic [2:0]     op;
  logic           sign_a;   // remainder takes the dividend's sign
  logic           neg_res;  // negate product / quotient at the end
  logic [N-1:0]   opnd;     // |a| as multiplicand, or |b| as divisor
  logic [CW-1:0]  cnt;

  // Working registers
  logic [2*N-1:0] acc;      // product accumulator; low half starts as the multiplier
  logic [N:0]     rem;      // partial remainder
  logic [N-1:0]   quo;      // dividend shifts out of the top while quotient bits shift in

  // ---------------------------------------------------------------
  // Start-edge decode
  // ---------------------------------------------------------------
  logic         accept;
  logic         is_div;
  logic         a_signed;
  logic         b_signed;
  logic         in_sa;
  logic         in_sb;
  logic [N-1:0] abs_a;
  logic [N-1:0] abs_b;
  logic         b_zero;
  logic         div_ovf;
  logic         fast;

  always_comb begin
    accept   = (state == IDLE) && start;
    is_div   = funct3[2];
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    in_sa    = a_signed && a[N-1];
    in_sb    = b_signed && b[N-1];
    // Negating the most negative value wraps to itself, which is the
    // correct magnitude when read as unsigned.
    abs_a    = in_sa ? -a : a;
    abs_b    = in_sb ? -b : b;
    b_zero   = (b == '0);
    div_ovf  = funct3[2] && !funct3[0] &&
               (a == {1'b1, {(N-1){1'b0}}}) && (b == {N{1'b1}});
    fast     = is_div && (b_zero || div_ovf);
  end

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = fast ? FINISH : RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(N - 1)) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // ---------------------------------------------------------------
  // Per-iteration datapath
  // ---------------------------------------------------------------
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     div_shift;
  logic [N+1:0]   div_diff;
  logic           div_ok;

  always_comb begin
    // Add the multiplicand into the upper half when the multiplier LSB is
    // set, then shift the whole accumulator right by one.
    mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : {(N+1){1'b0}});
    mul_next  = {mul_sum, acc[N-1:1]};
    // Trial subtraction of the divisor from the shifted remainder. A set
    // remainder MSB means the shifted value already exceeds any divisor; the
    // low bits of the difference are still exact in that case.
    div_shift = {rem[N-1:0], quo[N-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    div_ok    = rem[N] || !div_diff[N+1];
  end

  // ---------------------------------------------------------------
  // Sign fix and result select
  // ---------------------------------------------------------------
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;
  logic [N-1:0]   res_nxt;

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -quo : quo;
    rem_fix  = sign_a ? -rem[N-1:0] : rem[N-1:0];
    case (op)
      3'b000:                 res_nxt = prod_fix[N-1:0];
      3'b001, 3'b010, 3'b011: res_nxt = prod_fix[2*N-1:N];
      3'b100, 3'b101:         res_nxt = quo_fix;
      default:                res_nxt = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------
  // Working registers, result and done
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op      <= '0;
      sign_a  <= 1'b0;
      neg_res <= 1'b0;
      opnd    <= '0;
      cnt     <= '0;
      acc     <= '0;
      rem     <= '0;
      quo     <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (accept) begin
        op      <= funct3;
        sign_a  <= in_sa;
        // Divide-by-zero returns all ones regardless of operand signs.
        neg_res <= (in_sa ^ in_sb) && !(is_div && b_zero);
        cnt     <= '0;
        if (is_div) begin
          opnd <= abs_b;
          acc  <= '0;
          // Divide-by-zero preloads quotient=all ones and remainder=|a|;
          // the end-of-op sign fix then restores the remainder to a.
          // Signed overflow preloads quotient=|a| (already 2^(N-1)), rem=0.
          quo  <= b_zero ? {N{1'b1}} : abs_a;
          rem  <= b_zero ? {1'b0, abs_a} : {(N+1){1'b0}};
        end else begin
          opnd <= abs_a;
          acc  <= {{N{1'b0}}, abs_b};
          quo  <= '0;
          rem  <= '0;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (op[2]) begin
          quo <= {quo[N-2:0], div_ok};
          rem <= div_ok ? div_diff[N:0] : div_shift;
        end else begin
          acc <= mul_next;
        end
      end else if (state == FINISH) begin
        result <= res_nxt;
      end
    end
  end

endmodule
